// File: rtl/e_stage_ctrl_md.sv
// Execute-stage control: D->E control register, ALU/Tnew/md decode, and the
// multi-cycle mult/div sequencer that drives busy/done and the D-stage md stall.
module e_stage_ctrl_md #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_stall_e,
  input  logic       i_flush_e,
  input  logic [5:0] i_op_d,
  input  logic [5:0] i_func_d,
  input  logic       i_regwr_d,
  output logic [5:0] o_op_e,
  output logic [5:0] o_func_e,
  output logic       o_regwr_e,
  output logic [2:0] o_alu_ctr,
  output logic       o_alub_sel,
  output logic [1:0] o_tnew_e,
  output logic [2:0] o_md_op,
  output logic       o_md_start,
  output logic       o_md_busy,
  output logic       o_md_done,
  output logic       o_md_stall
);

  localparam logic [5:0] OP_R = 6'h00, OP_ORI = 6'h0d, OP_LUI = 6'h0f,
                         OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] F_ADDU = 6'h21, F_SUBU = 6'h23, F_MFHI = 6'h10, F_MTHI = 6'h11,
                         F_MFLO = 6'h12, F_MTLO = 6'h13, F_MULT = 6'h18, F_MULTU = 6'h19,
                         F_DIV = 6'h1a, F_DIVU = 6'h1b;
  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  logic [5:0]       r_op_e, r_func_e;
  logic             r_regwr_e, r_e_new;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_md_start, w_md_d, w_is_div;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op_e    <= '0;
      r_func_e  <= '0;
      r_regwr_e <= 1'b0;
      r_e_new   <= 1'b0;
    end else if (i_flush_e) begin
      r_op_e    <= '0;
      r_func_e  <= '0;
      r_regwr_e <= 1'b0;
      r_e_new   <= 1'b0;
    end else if (i_stall_e) begin
      r_e_new   <= 1'b0;
    end else begin
      r_op_e    <= i_op_d;
      r_func_e  <= i_func_d;
      r_regwr_e <= i_regwr_d;
      r_e_new   <= 1'b1;
    end
  end

  always_comb begin
    o_alu_ctr  = 3'd0;
    o_alub_sel = 1'b0;
    o_tnew_e   = 2'd0;
    o_md_op    = 3'd0;
    case (r_op_e)
      OP_R: case (r_func_e)
        F_ADDU:  o_tnew_e = 2'd1;
        F_SUBU:  begin o_alu_ctr = 3'd1; o_tnew_e = 2'd1; end
        F_MFHI,
        F_MFLO:  o_tnew_e = 2'd1;
        F_MULT:  o_md_op = 3'd1;
        F_MULTU: o_md_op = 3'd2;
        F_DIV:   o_md_op = 3'd3;
        F_DIVU:  o_md_op = 3'd4;
        F_MTHI:  o_md_op = 3'd5;
        F_MTLO:  o_md_op = 3'd6;
        default: ;
      endcase
      OP_ORI:  begin o_alu_ctr = 3'd2; o_alub_sel = 1'b1; o_tnew_e = 2'd1; end
      OP_LUI:  begin o_alu_ctr = 3'd3; o_alub_sel = 1'b1; o_tnew_e = 2'd1; end
      OP_LW:   begin o_alub_sel = 1'b1; o_tnew_e = 2'd2; end
      OP_SW:   o_alub_sel = 1'b1;
      default: ;
    endcase
  end

  // Only a freshly loaded instruction can start the unit, so a held one never restarts.
  assign w_md_start = r_e_new && (o_md_op inside {3'd1, 3'd2, 3'd3, 3'd4});
  assign w_is_div   = (o_md_op == 3'd3) || (o_md_op == 3'd4);

  always_comb begin
    w_md_d = 1'b0;
    if (i_op_d == OP_R)
      w_md_d = i_func_d inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_md_start) begin
          r_cnt   <= w_is_div ? DIV_CNT : MULT_CNT;
          r_state <= BUSY;
        end
        BUSY: if (r_cnt == CNT_W'(1)) begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end else begin
          r_cnt   <= r_cnt - CNT_W'(1);
        end
        default: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_op_e     = r_op_e;
  assign o_func_e   = r_func_e;
  assign o_regwr_e  = r_regwr_e;
  assign o_md_start = w_md_start;
  assign o_md_busy  = w_md_start || (r_state == BUSY);
  assign o_md_done  = (r_state == BUSY) && (r_cnt == CNT_W'(1));
  assign o_md_stall = o_md_busy && w_md_d;

endmodule

// File: tb/tb_e_stage_ctrl_md.sv
// Bench for e_stage_ctrl_md: table-driven decode model plus a start-cycle/latency
// window model of the md unit, checked every cycle, with literal pins on top.
module tb_e_stage_ctrl_md;
  localparam int MULT_LAT = 5, DIV_LAT = 10;

  logic clk = 1'b0, rst_n = 1'b0, stall_e = 1'b0, flush_e = 1'b0, regwr_d = 1'b0;
  logic [5:0] op_d = '0, func_d = '0;
  logic [5:0] op_e, func_e;
  logic regwr_e, alub_sel, md_start, md_busy, md_done, md_stall;
  logic [2:0] alu_ctr, md_op;
  logic [1:0] tnew_e;

  int n_cmp = 0, n_bad = 0;

  e_stage_ctrl_md #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall_e(stall_e), .i_flush_e(flush_e),
    .i_op_d(op_d), .i_func_d(func_d), .i_regwr_d(regwr_d),
    .o_op_e(op_e), .o_func_e(func_e), .o_regwr_e(regwr_e), .o_alu_ctr(alu_ctr),
    .o_alub_sel(alub_sel), .o_tnew_e(tnew_e), .o_md_op(md_op), .o_md_start(md_start),
    .o_md_busy(md_busy), .o_md_done(md_done), .o_md_stall(md_stall));

  always #5 clk = ~clk;

  // Instruction table: {D-side md family, alu_ctr, alub_sel, tnew, md_op}
  logic [9:0] tbl [logic [11:0]];
  function automatic logic [11:0] key(input logic [5:0] op, input logic [5:0] fn);
    return (op == 6'h00) ? {6'h00, fn} : {op, 6'h00};
  endfunction
  function automatic logic [9:0] dec(input logic [5:0] op, input logic [5:0] fn);
    logic [11:0] k;
    k = key(op, fn);
    return tbl.exists(k) ? tbl[k] : 10'd0;
  endfunction
  initial begin
    tbl[key(6'h00, 6'h21)] = {1'b0, 3'd0, 1'b0, 2'd1, 3'd0}; // addu
    tbl[key(6'h00, 6'h23)] = {1'b0, 3'd1, 1'b0, 2'd1, 3'd0}; // subu
    tbl[key(6'h00, 6'h08)] = {1'b0, 3'd0, 1'b0, 2'd0, 3'd0}; // jr
    tbl[key(6'h00, 6'h10)] = {1'b1, 3'd0, 1'b0, 2'd1, 3'd0}; // mfhi
    tbl[key(6'h00, 6'h12)] = {1'b1, 3'd0, 1'b0, 2'd1, 3'd0}; // mflo
    tbl[key(6'h00, 6'h11)] = {1'b1, 3'd0, 1'b0, 2'd0, 3'd5}; // mthi
    tbl[key(6'h00, 6'h13)] = {1'b1, 3'd0, 1'b0, 2'd0, 3'd6}; // mtlo
    tbl[key(6'h00, 6'h18)] = {1'b1, 3'd0, 1'b0, 2'd0, 3'd1}; // mult
    tbl[key(6'h00, 6'h19)] = {1'b1, 3'd0, 1'b0, 2'd0, 3'd2}; // multu
    tbl[key(6'h00, 6'h1a)] = {1'b1, 3'd0, 1'b0, 2'd0, 3'd3}; // div
    tbl[key(6'h00, 6'h1b)] = {1'b1, 3'd0, 1'b0, 2'd0, 3'd4}; // divu
    tbl[key(6'h0d, 6'h00)] = {1'b0, 3'd2, 1'b1, 2'd1, 3'd0}; // ori
    tbl[key(6'h0f, 6'h00)] = {1'b0, 3'd3, 1'b1, 2'd1, 3'd0}; // lui
    tbl[key(6'h23, 6'h00)] = {1'b0, 3'd0, 1'b1, 2'd2, 3'd0}; // lw
    tbl[key(6'h2b, 6'h00)] = {1'b0, 3'd0, 1'b1, 2'd0, 3'd0}; // sw
  end

  // Model: E-register contents plus the window [m_st, m_st+m_lat) of the active md op.
  logic [5:0] m_op, m_func;
  logic m_regwr, m_new;
  int m_cyc, m_st, m_lat;
  logic [9:0] m_dec, m_decd;
  logic m_start, m_win, m_busy, m_done, m_stall;
  always_comb begin
    m_dec   = dec(m_op, m_func);
    m_decd  = dec(op_d, func_d);
    m_start = m_new && (m_dec[2:0] >= 3'd1) && (m_dec[2:0] <= 3'd4);
    m_win   = (m_cyc > m_st) && (m_cyc < m_st + m_lat);
    m_busy  = m_start || m_win;
    m_done  = m_win && (m_cyc == m_st + m_lat - 1);
    m_stall = m_busy && m_decd[9];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_op <= '0; m_func <= '0; m_regwr <= 1'b0; m_new <= 1'b0;
      m_cyc <= 0; m_st <= -100; m_lat <= 0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (m_start && !m_win) begin
        m_st  <= m_cyc;
        m_lat <= (m_dec[2:0] >= 3'd3) ? DIV_LAT : MULT_LAT;
      end
      if (flush_e) begin
        m_op <= '0; m_func <= '0; m_regwr <= 1'b0; m_new <= 1'b0;
      end else if (stall_e) begin
        m_new <= 1'b0;
      end else begin
        m_op <= op_d; m_func <= func_d; m_regwr <= regwr_d; m_new <= 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d expected=%0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("op_e", int'(op_e), int'(m_op));
    chk("func_e", int'(func_e), int'(m_func));
    chk("regwr_e", int'(regwr_e), int'(m_regwr));
    chk("alu_ctr", int'(alu_ctr), int'(m_dec[8:6]));
    chk("alub_sel", int'(alub_sel), int'(m_dec[5]));
    chk("tnew_e", int'(tnew_e), int'(m_dec[4:3]));
    chk("md_op", int'(md_op), int'(m_dec[2:0]));
    chk("md_start", int'(md_start), int'(m_start));
    chk("md_busy", int'(md_busy), int'(m_busy));
    chk("md_done", int'(md_done), int'(m_done));
    chk("md_stall", int'(md_stall), int'(m_stall));
  endtask

  // Every cycle passes through here: model compare at negedge, then inputs move at posedge+1.
  task automatic tick();
    @(negedge clk);
    cmp_model();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [5:0] op, input logic [5:0] fn, input logic rw);
    op_d = op; func_d = fn; regwr_d = rw;
  endtask

  function automatic int all_out();
    return int'({op_e, func_e, regwr_e, alu_ctr, alub_sel, tnew_e, md_op,
                 md_start, md_busy, md_done, md_stall});
  endfunction

  initial begin
    int ns, nb, nd, nst, done_at, s10;
    #2;
    chk("reset_outputs_zero", all_out(), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_nop_zero", all_out(), 0);

    set_d(6'h00, 6'h21, 1'b1); tick(); set_d(6'h00, 6'h00, 1'b0);
    chk("addu_func_e", int'(func_e), 'h21);
    chk("addu_regwr_e", int'(regwr_e), 1);
    chk("addu_alu_ctr", int'(alu_ctr), 0);
    chk("addu_tnew", int'(tnew_e), 1);
    chk("addu_alub_sel", int'(alub_sel), 0);
    set_d(6'h23, 6'h00, 1'b1); tick(); set_d(6'h00, 6'h00, 1'b0);
    chk("lw_tnew", int'(tnew_e), 2);
    chk("lw_alub_sel", int'(alub_sel), 1);
    set_d(6'h0f, 6'h00, 1'b1); tick(); set_d(6'h00, 6'h00, 1'b0);
    chk("lui_alu_ctr", int'(alu_ctr), 3);
    set_d(6'h0d, 6'h00, 1'b1); tick(); set_d(6'h00, 6'h23, 1'b1);
    chk("ori_alu_ctr", int'(alu_ctr), 2);
    tick(); set_d(6'h00, 6'h00, 1'b0);
    chk("subu_alu_ctr", int'(alu_ctr), 1);

    // mult: 5 busy cycles, one start, done only in the last
    set_d(6'h00, 6'h18, 1'b0); tick(); set_d(6'h00, 6'h00, 1'b0);
    ns = 0; nb = 0; nd = 0; done_at = -1;
    for (int i = 0; i < 12; i++) begin
      ns += int'(md_start); nb += int'(md_busy); nd += int'(md_done);
      if (md_done) done_at = i;
      tick();
    end
    chk("mult_starts", ns, 1);
    chk("mult_busy_cycles", nb, 5);
    chk("mult_done_pulses", nd, 1);
    chk("mult_done_cycle", done_at, 4);

    // div in E with mflo waiting in D
    set_d(6'h00, 6'h1a, 1'b0); tick(); set_d(6'h00, 6'h12, 1'b1);
    nb = 0; nst = 0; s10 = -1;
    for (int i = 0; i < 14; i++) begin
      nb += int'(md_busy); nst += int'(md_stall);
      if (i == 10) s10 = int'(md_stall);
      tick();
    end
    chk("div_busy_cycles", nb, 10);
    chk("div_md_stall_cycles", nst, 10);
    chk("div_stall_after_done", s10, 0);
    set_d(6'h00, 6'h00, 1'b0); tick();

    // div held by stall_e, then a flush mid-op
    set_d(6'h00, 6'h1b, 1'b0); tick(); stall_e = 1'b1; set_d(6'h00, 6'h00, 1'b0);
    ns = 0; nb = 0;
    for (int i = 0; i < 14; i++) begin
      ns += int'(md_start); nb += int'(md_busy);
      if (i == 3) stall_e = 1'b0;
      if (i == 5) flush_e = 1'b1;
      if (i == 6) flush_e = 1'b0;
      tick();
    end
    chk("stalled_div_starts", ns, 1);
    chk("stalled_flushed_div_busy", nb, 10);

    // reset in the 4th busy cycle of a div
    set_d(6'h00, 6'h1a, 1'b0); tick(); set_d(6'h00, 6'h00, 1'b0);
    tick(); tick(); tick();
    chk("div_busy_before_reset", int'(md_busy), 1);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_div_busy", int'(md_busy), 0);
    chk("reset_mid_div_all", all_out(), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("after_reset_idle", int'(md_busy), 0);

    // fresh mult after reset runs a full 5-cycle window
    set_d(6'h00, 6'h19, 1'b0); tick(); set_d(6'h00, 6'h00, 1'b0);
    nb = 0;
    for (int i = 0; i < 8; i++) begin
      nb += int'(md_busy);
      tick();
    end
    chk("multu_after_reset_busy", nb, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
